// File: rtl/if_pkg.sv
// Shared widths and the fetch-entry record for the instruction-fetch stage.
package if_pkg;
  localparam int XLEN        = 64;
  localparam int ILEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO of arbitrary element type; async reset, sync clear.
module fetch_fifo #(
  parameter type T     = logic [63:0],
  parameter int  DEPTH = 2,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          push_i,
  input  T              wdata_i,
  input  logic          pop_i,
  output T              rdata_o,
  output logic          empty_o,
  output logic          full_o,
  output logic [CW-1:0] count_o
);
  T              mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rptr_q];
  // A pop frees the slot the same cycle, so push-on-full is legal alongside it.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (do_push && !clr_i) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (clr_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues credit-limited fetches, queues {instr, pc}.
// Optional perf counters (fetched/stall/dropped) are built when IF_PERF_EN is defined.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        fetch_valid,
  input  logic        fetch_ready,
  output logic [31:0] fetch_instr,
  output logic [63:0] fetch_pc,
  output logic        if_flush
`ifdef IF_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_dropped
`endif
);
  localparam int CW = $clog2(QDEPTH + 1);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   out_q, out_d, drop_q, drop_d;
  logic [CW:0]     used;
  logic            pop_fire, req_hs, rsp_keep, rsp_drop;
  logic [XLEN-1:0] pend_head;
  fetch_entry_t    oq_wdata, oq_head;
  logic            oq_empty, oq_full, pend_empty, pend_full;
  logic [CW-1:0]   oq_count, pend_count;
  logic            unused_fifo_status;

  assign unused_fifo_status = ^{oq_full, pend_empty, pend_full, pend_count};

  assign pop_fire = fetch_valid && fetch_ready && !redirect_valid;
  // A pop in this cycle hands its slot back, which keeps single-cycle memory at full rate.
  assign used     = {1'b0, out_q} + {1'b0, oq_count} - (CW+1)'(pop_fire);
  assign imem_req_valid = rst_n && !redirect_valid && (used < (CW+1)'(QDEPTH));
  assign imem_req_addr  = pc_q;
  assign req_hs   = imem_req_valid && imem_req_ready;
  assign rsp_keep = imem_rsp_valid && !redirect_valid && (drop_q == '0);
  assign rsp_drop = imem_rsp_valid && !rsp_keep;
  assign if_flush = redirect_valid && rst_n;

  always_comb begin
    pc_d   = pc_q;
    out_d  = out_q + CW'(req_hs) - CW'(imem_rsp_valid);
    drop_d = drop_q;
    if (redirect_valid) begin
      pc_d   = {redirect_pc[63:2], 2'b00};
      drop_d = out_q - CW'(imem_rsp_valid);
    end else begin
      if (req_hs) pc_d = pc_q + XLEN'(INSTR_BYTES);
      if (imem_rsp_valid && drop_q != '0) drop_d = drop_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC;
      out_q  <= '0;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      out_q  <= out_d;
      drop_q <= drop_d;
    end
  end

  fetch_fifo #(.T(logic [XLEN-1:0]), .DEPTH(QDEPTH)) u_pend_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (redirect_valid),
    .push_i  (req_hs),
    .wdata_i (pc_q),
    .pop_i   (rsp_keep),
    .rdata_o (pend_head),
    .empty_o (pend_empty),
    .full_o  (pend_full),
    .count_o (pend_count)
  );

  assign oq_wdata = '{pc: pend_head, instr: imem_rsp_data};

  fetch_fifo #(.T(fetch_entry_t), .DEPTH(QDEPTH)) u_out_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (redirect_valid),
    .push_i  (rsp_keep),
    .wdata_i (oq_wdata),
    .pop_i   (pop_fire),
    .rdata_o (oq_head),
    .empty_o (oq_empty),
    .full_o  (oq_full),
    .count_o (oq_count)
  );

  assign fetch_valid = !oq_empty;
  assign fetch_instr = oq_empty ? '0 : oq_head.instr;
  assign fetch_pc    = oq_empty ? '0 : oq_head.pc;

`ifdef IF_PERF_EN
  logic [31:0] fetched_q, stall_q, dropped_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetched_q <= '0;
      stall_q   <= '0;
      dropped_q <= '0;
    end else begin
      if (pop_fire)                    fetched_q <= fetched_q + 32'd1;
      if (fetch_valid && !fetch_ready) stall_q   <= stall_q + 32'd1;
      if (rsp_drop)                    dropped_q <= dropped_q + 32'd1;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_stall   = stall_q;
  assign perf_dropped = dropped_q;
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: in-order memory model with random latency plus a
// reference model that predicts the fetch stream as consecutive PCs per redirect.
module tb_if_fetch_unit;
  localparam logic [63:0] RESET_PC = 64'h0;
  localparam int          QDEPTH   = 2;

  logic        clk, rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        fetch_valid, fetch_ready;
  logic [31:0] fetch_instr;
  logic [63:0] fetch_pc;
  logic        if_flush;
`ifdef IF_PERF_EN
  logic [31:0] perf_fetched, perf_stall, perf_dropped;
`endif

  if_fetch_unit #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_valid    (fetch_valid),
    .fetch_ready    (fetch_ready),
    .fetch_instr    (fetch_instr),
    .fetch_pc       (fetch_pc),
    .if_flush       (if_flush)
`ifdef IF_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall),
    .perf_dropped   (perf_dropped)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    int          rdy;
  } mreq_t;

  mreq_t       mq[$];
  int          cyc_n, last_rdy, lat_min, lat_max;
  int          total, bad;
  int          occ, stale, n_acc;
  logic [63:0] exp_pc, exp_req;
  logic [31:0] e_fetched, e_stall, e_dropped;

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    occ = 0; stale = 0; last_rdy = 0;
    exp_pc = RESET_PC; exp_req = RESET_PC;
    e_fetched = 0; e_stall = 0; e_dropped = 0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
  endtask

  // One clock: check at settle point, advance model on the edge, drive memory response.
  task automatic tick();
    logic        fv_m, pop, ev, hs, rsp, redir, fr, rin;
    logic [63:0] a, tgt;
    int          used, rdy;
    #1;
    fv_m = (occ > 0);
    pop  = fv_m && fetch_ready && !redirect_valid && rst_n;
    used = mq.size() + occ - (pop ? 1 : 0);
    ev   = rst_n && !redirect_valid && (used < QDEPTH);
    chk("if_flush", if_flush, rst_n && redirect_valid);
    chk("fetch_valid", fetch_valid, fv_m);
    chk("req_valid", imem_req_valid, ev);
    if (ev) chk("req_addr", imem_req_addr, exp_req);
    if (fv_m) begin
      chk("fetch_pc", fetch_pc, exp_pc);
      chk("fetch_instr", fetch_instr, instr_of(exp_pc));
    end else begin
      chk("fetch_pc_idle", fetch_pc, 0);
      chk("fetch_instr_idle", fetch_instr, 0);
    end
    hs = imem_req_valid && imem_req_ready && rst_n;
    a = imem_req_addr; rsp = imem_rsp_valid; redir = redirect_valid;
    tgt = redirect_pc; fr = fetch_ready; rin = imem_req_ready;
    rdy = cyc_n + $urandom_range(lat_max, lat_min);
    if (rdy <= last_rdy) rdy = last_rdy + 1;
    @(posedge clk);
    cyc_n++;
    if (!rst_n) model_reset();
    else begin
      if (fv_m && !fr) e_stall++;
      if (rsp && mq.size() > 0) void'(mq.pop_front());
      if (redir) begin
        if (rsp) e_dropped++;
        stale = mq.size();
        occ = 0;
        exp_pc = {tgt[63:2], 2'b00};
        exp_req = exp_pc;
      end else begin
        if (rsp) begin
          if (stale > 0) begin stale--; e_dropped++; end
          else occ++;
        end
        if (pop) begin occ--; exp_pc += 64'd4; e_fetched++; end
        if (ev && rin) exp_req += 64'd4;
      end
      if (hs) begin
        mq.push_back('{addr: a, rdy: rdy});
        last_rdy = rdy;
        n_acc++;
      end
    end
    @(negedge clk);
    if (rst_n && mq.size() > 0 && mq[0].rdy <= cyc_n) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_of(mq[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int cnt, acc0;
`ifdef IF_PERF_EN
    logic [31:0] pd0;
`endif
    total = 0; bad = 0; cyc_n = 0; n_acc = 0;
    lat_min = 1; lat_max = 1;
    rst_n = 1'b0; imem_req_ready = 1'b1; fetch_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0;
    model_reset();
    @(negedge clk); #1;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_req_addr", imem_req_addr, RESET_PC);
    chk("rst_fetch_valid", fetch_valid, 0);
    tick(); tick();
    rst_n = 1'b1;

    // Streaming from reset: first entry on cycle 2, then one per cycle.
    #1;
    chk("t1_c0_req", imem_req_valid, 1);
    tick();
    chk("t1_c1_valid", fetch_valid, 0);
    tick();
    chk("t1_c2_valid", fetch_valid, 1);
    chk("t1_c2_pc", fetch_pc, 64'h0);
    cnt = 0;
    repeat (10) begin
      if (fetch_valid) cnt++;
      tick();
    end
    chk("t1_throughput", cnt, 10);

    // Back-pressure: credit stops issue after two accepted requests.
    fetch_ready = 1'b0;
    do_reset();
    acc0 = n_acc;
    repeat (5) tick();
    chk("t2_accepted", n_acc - acc0, 2);
    chk("t2_req_low", imem_req_valid, 0);
    fetch_ready = 1'b1;
    cnt = 0;
    repeat (3) begin
      if (fetch_valid) cnt++;
      tick();
    end
    chk("t2_pops", cnt, 3);

    // Memory not ready at pc 0x10: address holds, queue drains, then resumes.
    do_reset();
    for (int k = 0; k < 20 && exp_req != 64'h10; k++) tick();
    imem_req_ready = 1'b0;
    repeat (3) begin
      tick();
      chk("t3_hold_addr", imem_req_addr, 64'h10);
    end
    chk("t3_drained", fetch_valid, 0);
    imem_req_ready = 1'b1;
    #1;
    chk("t3_resume_valid", imem_req_valid, 1);
    chk("t3_resume_addr", imem_req_addr, 64'h10);
    tick();
    chk("t3_next_addr", imem_req_addr, 64'h14);

    // Redirect with 0x20/0x24 outstanding; both responses must be dropped.
    lat_min = 6; lat_max = 6;
    redirect_valid = 1'b1; redirect_pc = 64'h20;
    tick();
    redirect_valid = 1'b0;
    for (int k = 0; k < 20 && !(mq.size() == 2 && mq[0].addr == 64'h20); k++) tick();
    chk("t4_outstanding", mq.size(), 2);
`ifdef IF_PERF_EN
    pd0 = perf_dropped;
`endif
    redirect_valid = 1'b1; redirect_pc = 64'h103;
    #1;
    chk("t4_flush", if_flush, 1);
    tick();
    redirect_valid = 1'b0;
    for (int k = 0; k < 30 && !fetch_valid; k++) tick();
    chk("t4_valid", fetch_valid, 1);
    chk("t4_fetch_pc", fetch_pc, 64'h100);
`ifdef IF_PERF_EN
    chk("t4_perf_dropped", perf_dropped - pd0, 2);
`endif

    // Redirect coinciding with a response and a pop.
    lat_min = 1; lat_max = 1;
    for (int k = 0; k < 30 && !(imem_rsp_valid && fetch_valid); k++) tick();
    chk("t5_setup", imem_rsp_valid && fetch_valid, 1);
    redirect_valid = 1'b1; redirect_pc = 64'h200;
    tick();
    redirect_valid = 1'b0;
    chk("t5_empty", fetch_valid, 0);
    for (int k = 0; k < 20 && !fetch_valid; k++) tick();
    chk("t5_target_pc", fetch_pc, 64'h200);

    // Reset mid-stream.
    repeat (3) tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_valid", fetch_valid, 0);
    chk("t6_flush", if_flush, 0);
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk("t6_first_valid", imem_req_valid, 1);
    chk("t6_first_addr", imem_req_addr, RESET_PC);

    // Random traffic, including redirects near the top of the address space.
    lat_min = 1; lat_max = 3;
    for (int i = 0; i < 400; i++) begin
      imem_req_ready = ($urandom_range(3, 0) != 0);
      fetch_ready    = ($urandom_range(3, 0) != 0);
      redirect_valid = ($urandom_range(19, 0) == 0);
      redirect_pc    = ($urandom_range(3, 0) == 0) ? 64'hFFFF_FFFF_FFFF_FFF5
                                                   : {$urandom, $urandom};
      if (i == 200) begin
        rst_n = 1'b0;
        model_reset();
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end
    redirect_valid = 1'b0; imem_req_ready = 1'b1; fetch_ready = 1'b1;
    cnt = 0;
    repeat (20) begin
      if (fetch_valid) cnt++;
      tick();
    end
    chk("drain_progress", cnt >= 10, 1);
`ifdef IF_PERF_EN
    chk("perf_fetched", perf_fetched, e_fetched);
    chk("perf_stall", perf_stall, e_stall);
    chk("perf_dropped", perf_dropped, e_dropped);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage; sits directly upstream of the IF/ID pipeline buffer.
- Owns the 64-bit PC and issues 32-bit instruction requests to instruction memory over a valid/ready request channel with an in-order response channel.
- Buffers returned instructions in a small queue and presents {instr, pc} pairs to IF/ID.
- Handles redirects (taken branch/jump): discards in-flight fetches and raises the IF/ID flush.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- QDEPTH, 2, output-queue depth; also the credit limit on outstanding requests plus queued entries (power of two, ≥2).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_req_addr  output  64  fetch address (bits [1:0] always 0).
- imem_rsp_valid  input  1  response valid; exactly one per accepted request, in order, latency ≥1 cycle.
- imem_rsp_data  input  32  returned instruction.
- redirect_valid  input  1  redirect PC this cycle.
- redirect_pc  input  64  redirect target.
- fetch_valid  output  1  {fetch_instr, fetch_pc} valid.
- fetch_ready  input  1  IF/ID write enable; entry consumed when fetch_valid && fetch_ready.
- fetch_instr  output  32  instruction to IF/ID.
- fetch_pc  output  64  PC of fetch_instr.
- if_flush  output  1  flush to IF/ID.

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC; queues empty; outstanding=0; drop_cnt=0. Outputs: imem_req_valid=0, imem_req_addr=RESET_PC, fetch_valid=0, fetch_instr=0, fetch_pc=0, if_flush=0.
- Reset mid-operation aborts everything immediately; instruction memory is reset by the same rst_n, so no stale responses arrive.
- Request issue:
  - imem_req_addr=pc.
  - imem_req_valid=1 when (outstanding + occupancy) < QDEPTH and !redirect_valid.
  - On handshake: pc+4 (64-bit wraparound), pc pushed to pending-PC FIFO, outstanding+1.
  - While valid and not ready, addr holds stable.
- Response: on imem_rsp_valid, outstanding-1.
  - drop_cnt>0: response discarded, drop_cnt-1.
  - Otherwise: pending PC popped; {data, pc} pushed to output queue.
- Latency: request accepted cycle N, response cycle N+1 → fetch_valid at N+2. Sustained throughput of one instruction per cycle with 1-cycle memory and QDEPTH ≥2.
- Output: fetch_valid = queue non-empty; fetch_instr/fetch_pc = queue head, driven 0 when empty.
  - Pop on fetch_valid && fetch_ready.
  - Push and pop in the same cycle are allowed; the credit rule guarantees the queue never overflows.
- Redirect (redirect_valid=1, highest priority):
  - pc <= {redirect_pc[63:2], 2'b00}.
  - Output queue and pending-PC FIFO cleared.
  - drop_cnt <= outstanding minus 1 if a response arrives this cycle (that response is dropped immediately).
  - No request issued; any pop this cycle is ignored.
  - if_flush = redirect_valid (combinational, same cycle).
- Back-to-back redirects: the latest target wins; drop_cnt is recomputed from the current outstanding each time.
- Counter widths: $clog2(QDEPTH+1).

Optional Feature:
- Macro IF_PERF_EN.
- Defined: adds outputs perf_fetched[31:0] (queue pops), perf_stall[31:0] (cycles with fetch_valid && !fetch_ready), perf_dropped[31:0] (discarded responses). All three reset to 0, wrap at 2^32.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package if_pkg:
  - XLEN=64, ILEN=32, INSTR_BYTES=4.
  - typedef fetch_entry_t {logic [63:0] pc; logic [31:0] instr;}.
- Sub-module fetch_fifo:
  - Parameterised type/depth synchronous FIFO with async active-low reset and a synchronous clear input.
  - Instantiated twice: pending-PC FIFO and output queue.

Test Plan:
- Memory always ready, 1-cycle latency, fetch_ready=1 from reset (RESET_PC=0) → requests 0x0,0x4,0x8…; fetch_pc 0x0 valid at cycle 2, then one entry per cycle in order.
- fetch_ready=0 for 5 cycles → imem_req_valid drops after 2 accepted requests, no loss or duplication; release yields pc 0x0,0x4,0x8 in order.
- imem_req_ready=0 for 3 cycles at pc 0x10 → imem_req_addr held at 0x10, no queue entries; resumes at 0x10 then 0x14.
- Two requests outstanding (0x20, 0x24), redirect to 0x103 → if_flush high that cycle; both responses dropped (perf_dropped=2 with IF_PERF_EN); next fetch_pc=0x100.
- Redirect in same cycle as a response arrival and a pop → response dropped, queue empty next cycle, fetch_valid=0 until the target's response returns.
- rst_n asserted mid-stream → fetch_valid=0 and if_flush=0 immediately; after release, first request addr = RESET_PC.
